imm_gen_stage: RTL
==================

# imm_gen_stage

Registered, parametrised immediate-generation stage for the RISC-V decode path. It accepts one instruction plus its PC per valid/ready handshake and decodes every immediate format for RV32 or RV64. It also computes the PC-relative target and flags unrecognised encodings. Results are held in a 2-entry skid buffer so back-pressure from the execute stage never drops or reorders instructions.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64.
- SHAMT_MODE, 1, when 1, OP-IMM shifts yield a zero-extended shamt instead of a sign-extended I-immediate.
- ZIMM_EN, 1, when 1, SYSTEM CSR*I (funct3 1xx) yields zero-extended in[19:15].

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
- out_target  out  XLEN  in_pc + out_imm for BRANCH/JAL/AUIPC; 0 otherwise.
- out_illegal  out  1  encoding not recognised.
- out_pc  out  XLEN  pc passthrough.

## Operation
- Transfers occur on a rising edge where valid and ready are both 1.
- I format (imm = sign-extend in[31:20]): LOAD, JALR, MISC-MEM, OP-IMM non-shift, and SYSTEM when not ZIMM.
- S format (imm = sign-extend {in[31:25], in[11:7]}): STORE.
- B format (imm = sign-extend {in[31], in[7], in[30:25], in[11:8], 0}): BRANCH.
- U format (imm = {in[31:12], 12'b0}, sign-extended from bit 31 to XLEN): LUI, AUIPC.
- J format (imm = sign-extend {in[31], in[19:12], in[20], in[30:21], 0}): JAL.
- NONE format (imm = 0): OP, and OP-32 when XLEN=64.
- SHAMT:
  - Applies to OP-IMM funct3 001/101 when SHAMT_MODE=1.
  - imm = zero-extended in[24:20] for XLEN=32, in[25:20] for XLEN=64.
  - OP-IMM-32 (XLEN=64 only) always uses in[24:20].
  - Illegal when any of: in[25]=1 at XLEN=32; upper funct bits not 0 (funct3 001) or not 0/0100000 (funct3 101).
- Illegal encodings:
  - in[1:0] != 11.
  - Opcode outside the recognised set.
  - OP-IMM-32/OP-32 when XLEN=32.
  - Required response: out_imm=0, out_fmt=NONE, out_illegal=1, out_target=0. The instruction still flows through the buffer.
- Target arithmetic wraps modulo 2^XLEN.
- Buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main register holds data; out_valid=1, in_ready=1.
  - TWO: main and skid both full; out_valid=1, in_ready=0.
- Transitions:
  - EMPTY → ONE on accept.
  - ONE → EMPTY on drain with no accept.
  - ONE stays ONE on simultaneous accept and drain; the new entry replaces main.
  - ONE → TWO on accept while out_ready=0.
  - TWO → ONE on drain; skid moves to main.
- Order is strictly FIFO.

## Timing
- Latency is 1 cycle: accepted at edge k, visible on out_* after edge k, valid for the cycle before edge k+1.
- Throughput is 1 per cycle while out_ready=1.
- in_ready is registered and falls the cycle after the buffer reaches TWO. The accept that caused TWO was legal.
- out_* are stable while out_valid=1 and out_ready=0.
- Reset (any time, including mid-transfer):
  - Buffer goes to EMPTY; all data outputs = 0; out_valid=0; in_ready=0.
  - in_ready rises on the first clk edge after rst_n deasserts.
  - In-flight entries are discarded.

## Structure
- imm_pkg holds the opcode constants (7-bit), funct3 shift codes, and the fmt_t enum (3-bit, values above).
- Sub-module imm_decode is purely combinational: in_instr, in_pc → imm, fmt, target, illegal, with the same parameters.
- imm_gen_stage instantiates imm_decode once, on the input side, and registers its outputs into the main/skid registers.

## Test plan
- XLEN=32: 0xFFF00093 (addi -1) → imm 0xFFFFFFFF, fmt I. 0xFE000EE3 (beq -4) at pc 0x100 → imm 0xFFFFFFFC, fmt B, target 0xFC.
- XLEN=32, SHAMT_MODE=1:
  - 0x4030D093 (srai 3) → imm 3, fmt SHAMT, not 0x403.
  - 0x02009093 (in[25]=1) → illegal=1, imm 0.
- XLEN=64: 0x800000B7 (lui) → imm 0xFFFFFFFF80000000, fmt U. 0x0000007F → illegal=1, fmt NONE, imm 0.
- Back-pressure:
  - Hold out_ready=0 and send A then B on consecutive cycles → in_ready=0 the cycle after B.
  - Release out_ready → A then B emitted in order, no loss or duplication, in_ready returns to 1.
- Streaming: 100 random legal instructions with out_ready=1 → one result per cycle, 1-cycle latency, matches the reference model.
- Reset while buffer is TWO → out_valid=0 and in_ready=0 immediately; in_ready=1 one edge after release; no stale output.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared constants and types for the RISC-V immediate-generation stage.
package imm_pkg;

  // Major opcodes, all 7 bits. in[1:0] is always 2'b11 here, so any
  // compressed or reserved quadrant never matches an entry.
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // funct3 codes for immediate shifts.
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } fmt_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  // Opcodes whose result also carries pc + imm.
  function automatic logic is_pc_relative(input logic [6:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_AUIPC);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction + pc -> imm, fmt, target, illegal.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit SHAMT_MODE = 1'b1,
  parameter bit ZIMM_EN    = 1'b1
) (
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_imm,
  output fmt_t            o_fmt,
  output logic [XLEN-1:0] o_target,
  output logic            o_illegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_is_shift;
  logic       w_wide_shamt;
  logic [5:0] w_shamt;
  logic [6:0] w_shift_hi;
  logic       w_shift_ok;
  fmt_t       w_fmt;
  logic       w_illegal;
  logic [XLEN-1:0] w_imm;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_is_shift = (w_funct3 == F3_SLL) || (w_funct3 == F3_SR);

  // RV64 OP-IMM shifts take a 6-bit shamt; RV32 and the *W forms take 5 bits,
  // so in[25] then belongs to the upper funct field that must be checked.
  assign w_wide_shamt = (XLEN == 64) && (w_opcode == OPC_OP_IMM);
  assign w_shamt      = w_wide_shamt ? i_instr[25:20] : {1'b0, i_instr[24:20]};
  assign w_shift_hi   = w_wide_shamt ? {i_instr[31:26], 1'b0} : i_instr[31:25];
  assign w_shift_ok   = (w_shift_hi == 7'b0000000) ||
                        ((w_funct3 == F3_SR) && (w_shift_hi == 7'b0100000));

  // Classify the encoding into an immediate format and a legality flag.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    w_fmt     = FMT_NONE;
    w_illegal = 1'b0;
    unique case (w_opcode)
      OPC_LOAD, OPC_JALR, OPC_MISC_MEM: w_fmt = FMT_I;
      OPC_OP_IMM: begin
        if (SHAMT_MODE && w_is_shift) begin
          w_fmt     = FMT_SHAMT;
          w_illegal = !w_shift_ok;
        end else begin
          w_fmt = FMT_I;
        end
      end
      OPC_OP_IMM_32: begin
        if (XLEN != 64) begin
          w_illegal = 1'b1;
        end else if (SHAMT_MODE && w_is_shift) begin
          w_fmt     = FMT_SHAMT;
          w_illegal = !w_shift_ok;
        end else begin
          w_fmt = FMT_I;
        end
      end
      OPC_STORE:          w_fmt = FMT_S;
      OPC_BRANCH:         w_fmt = FMT_B;
      OPC_LUI, OPC_AUIPC: w_fmt = FMT_U;
      OPC_JAL:            w_fmt = FMT_J;
      OPC_OP:             w_fmt = FMT_NONE;
      OPC_OP_32:          w_illegal = (XLEN != 64);
      OPC_SYSTEM:         w_fmt = (ZIMM_EN && w_funct3[2]) ? FMT_ZIMM : FMT_I;
      default:            w_illegal = 1'b1;
    endcase
    if (w_illegal) w_fmt = FMT_NONE;
  end

  // Assemble the immediate for the chosen format, extended to XLEN.
  always_comb begin
    w_imm = '0;
    unique case (w_fmt)
      FMT_I:     w_imm = XLEN'($signed(i_instr[31:20]));
      FMT_S:     w_imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
      FMT_B:     w_imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                        i_instr[11:8], 1'b0}));
      FMT_U:     w_imm = XLEN'($signed({i_instr[31:12], 12'b0}));
      FMT_J:     w_imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                        i_instr[30:21], 1'b0}));
      FMT_SHAMT: w_imm = XLEN'(w_shamt);
      FMT_ZIMM:  w_imm = XLEN'(i_instr[19:15]);
      default:   w_imm = '0;
    endcase
  end

  assign o_imm     = w_imm;
  assign o_fmt     = w_fmt;
  assign o_illegal = w_illegal;
  // Target wraps modulo 2^XLEN by construction of the XLEN-wide adder.
  assign o_target  = is_pc_relative(w_opcode) ? (i_pc + w_imm) : '0;

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decode on input, 2-entry skid buffer on output.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit SHAMT_MODE = 1'b1,
  parameter bit ZIMM_EN    = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_t            fmt;
    logic [XLEN-1:0] target;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } entry_t;

  buf_state_t r_state, w_state_nxt;
  logic       r_in_ready;
  entry_t     r_main, r_skid, w_new;
  logic       w_accept, w_drain;
  logic       w_load_main_new, w_load_skid, w_main_from_skid;

  logic [XLEN-1:0] w_dec_imm, w_dec_target;
  fmt_t            w_dec_fmt;
  logic            w_dec_illegal;

  imm_decode #(
    .XLEN       (XLEN),
    .SHAMT_MODE (SHAMT_MODE),
    .ZIMM_EN    (ZIMM_EN)
  ) u_decode (
    .i_instr   (in_instr),
    .i_pc      (in_pc),
    .o_imm     (w_dec_imm),
    .o_fmt     (w_dec_fmt),
    .o_target  (w_dec_target),
    .o_illegal (w_dec_illegal)
  );

  assign w_new = '{imm: w_dec_imm, fmt: w_dec_fmt, target: w_dec_target,
                   illegal: w_dec_illegal, pc: in_pc};

  assign out_valid = (r_state != BUF_EMPTY);
  assign w_accept  = in_valid && r_in_ready;
  assign w_drain   = out_valid && out_ready;

  // Next buffer state and which register loads what on this edge.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_new  = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    unique case (r_state)
      BUF_EMPTY: begin
        if (w_accept) begin
          w_state_nxt     = BUF_ONE;
          w_load_main_new = 1'b1;
        end
      end
      BUF_ONE: begin
        if (w_accept && w_drain) begin
          w_load_main_new = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = BUF_TWO;
          w_load_skid = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (w_drain) begin
          w_state_nxt      = BUF_ONE;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = BUF_EMPTY;
    endcase
  end

  // State register; in_ready is registered and held low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state    <= BUF_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != BUF_TWO);
    end
  end

  // Main/skid payload registers; the skid drains into main to keep FIFO order.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the payload registers are reset because the data outputs must read
    // zero after reset and no stale entry may survive it.
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_new)       r_main <= w_new;
      else if (w_main_from_skid) r_main <= r_skid;
      if (w_load_skid)           r_skid <= w_new;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_imm     = r_main.imm;
  assign out_fmt     = r_main.fmt;
  assign out_target  = r_main.target;
  assign out_illegal = r_main.illegal;
  assign out_pc      = r_main.pc;

endmodule
